// File: rtl/sync_down_counter_reload.sv
// Synchronous presettable down counter with reload register, one-shot or
// auto-reload operation, and a registered one-cycle Borrow pulse at
// terminal count. Cascade by driving a downstream Enable from Borrow.
module sync_down_counter_reload #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             Enable,
    input  logic             AutoReload,
    output logic [WIDTH-1:0] Count,
    output logic             Borrow,
    output logic             Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             borrow_q, borrow_d;
    logic             done_q, done_d;

    // Next-state logic: Load dominates, then terminal count / decrement in RUN.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        borrow_d = 1'b0;

        if (Load) begin
            count_d  = LoadValue;
            reload_d = LoadValue;
            state_d  = RUN;
        end else begin
            unique case (state_q)
                IDLE: begin
                    count_d = count_q;
                end
                RUN: begin
                    if (Enable) begin
                        if (count_q != '0) begin
                            count_d = count_q - 1'b1;
                        end else begin
                            // Zero is terminal count, so the decrement never wraps.
                            borrow_d = 1'b1;
                            if (AutoReload) begin
                                count_d = reload_q;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    count_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end

        done_d = (state_d == DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign Count  = count_q;
    assign Borrow = borrow_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_sync_down_counter_reload.sv
// Testbench for sync_down_counter_reload (WIDTH=4). An event-counting model
// (enabled edges since the last start) predicts outputs every cycle; directed
// literal checks pin the model at key points.
module tb_sync_down_counter_reload;

    localparam int unsigned WIDTH = 4;

    logic             Clock = 1'b0;
    logic             Resetn = 1'b1;
    logic             Load = 1'b0;
    logic [WIDTH-1:0] LoadValue = '0;
    logic             Enable = 1'b0;
    logic             AutoReload = 1'b0;
    logic [WIDTH-1:0] Count;
    logic             Borrow;
    logic             Done;

    int checks = 0;
    int errors = 0;

    sync_down_counter_reload #(.WIDTH(WIDTH)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Load       (Load),
        .LoadValue  (LoadValue),
        .Enable     (Enable),
        .AutoReload (AutoReload),
        .Count      (Count),
        .Borrow     (Borrow),
        .Done       (Done)
    );

    always #5 Clock = ~Clock;

    // Model: a start value N, and how many enabled edges have elapsed since
    // the last start. The (N+1)th enabled edge is terminal count.
    bit m_active  = 1'b0;
    bit m_stopped = 1'b0;
    bit m_borrow  = 1'b0;
    int m_n       = 0;
    int m_phase   = 0;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m_active  <= 1'b0;
            m_stopped <= 1'b0;
            m_borrow  <= 1'b0;
            m_n       <= 0;
            m_phase   <= 0;
        end else if (Load) begin
            m_active  <= 1'b1;
            m_stopped <= 1'b0;
            m_borrow  <= 1'b0;
            m_n       <= int'(LoadValue);
            m_phase   <= 0;
        end else if (m_active && !m_stopped && Enable) begin
            if (m_phase + 1 == m_n + 1) begin
                m_borrow <= 1'b1;
                if (AutoReload) m_phase <= 0;
                else begin
                    m_phase   <= m_phase + 1;
                    m_stopped <= 1'b1;
                end
            end else begin
                m_borrow <= 1'b0;
                m_phase  <= m_phase + 1;
            end
        end else begin
            m_borrow <= 1'b0;
        end
    end

    function automatic int exp_count();
        if (!m_active || m_stopped) return 0;
        return m_n - m_phase;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge Clock) begin
        check("model_count", int'(Count), exp_count());
        check("model_borrow", int'(Borrow), int'(m_borrow));
        check("model_done", int'(Done), int'(m_stopped));
    end

    task automatic step(input logic ld, input int lv, input logic en, input logic ar);
        Load       = ld;
        LoadValue  = lv[WIDTH-1:0];
        Enable     = en;
        AutoReload = ar;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        // Reset then idle
        #1 Resetn = 1'b0;
        @(posedge Clock); @(posedge Clock); #1;
        check("reset_count", int'(Count), 0);
        check("reset_borrow", int'(Borrow), 0);
        check("reset_done", int'(Done), 0);
        Resetn = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, 1'b0);
        check("idle_count", int'(Count), 0);
        check("idle_done", int'(Done), 0);

        // One-shot, load 3
        step(1'b1, 3, 1'b1, 1'b0);
        check("oneshot_load", int'(Count), 3);
        step(1'b0, 0, 1'b1, 1'b0);
        check("oneshot_c2", int'(Count), 2);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        check("oneshot_c0", int'(Count), 0);
        check("oneshot_no_borrow_yet", int'(Borrow), 0);
        step(1'b0, 0, 1'b1, 1'b0);
        check("oneshot_borrow", int'(Borrow), 1);
        check("oneshot_done", int'(Done), 1);
        for (int i = 0; i < 10; i++) step(1'b0, 0, 1'b1, 1'b0);
        check("oneshot_hold_count", int'(Count), 0);
        check("oneshot_hold_borrow", int'(Borrow), 0);
        check("oneshot_hold_done", int'(Done), 1);

        // Auto-reload, load 2: period 3
        step(1'b1, 2, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        check("auto_reload_count", int'(Count), 2);
        check("auto_reload_borrow", int'(Borrow), 1);
        for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b1, 1'b1);
        check("auto_after12_count", int'(Count), 2);
        check("auto_after12_borrow", int'(Borrow), 1);
        check("auto_done_low", int'(Done), 0);

        // Enable gating, load 5 one-shot, enable toggling 1,0,...
        step(1'b1, 5, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 0, (i % 2 == 0), 1'b0);
        check("gate_borrow", int'(Borrow), 1);
        check("gate_done", int'(Done), 1);

        // Load collision with terminal count, reload=4
        step(1'b1, 4, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b1);
        check("collide_pre_count", int'(Count), 0);
        step(1'b1, 9, 1'b1, 1'b1);
        check("collide_count", int'(Count), 9);
        check("collide_borrow", int'(Borrow), 0);
        check("collide_done", int'(Done), 0);

        // Maximum value 15, auto-reload
        step(1'b1, 15, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 0, 1'b1, 1'b1);
        check("max_zero", int'(Count), 0);
        step(1'b0, 0, 1'b1, 1'b1);
        check("max_reload", int'(Count), 15);
        check("max_borrow", int'(Borrow), 1);

        // Reload 0 with auto-reload: borrow on every enabled cycle
        step(1'b1, 0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 1'b1, 1'b1);
            check("zero_borrow", int'(Borrow), 1);
            check("zero_count", int'(Count), 0);
        end
        step(1'b0, 0, 1'b0, 1'b1);
        check("zero_disabled_borrow", int'(Borrow), 0);

        // AutoReload cleared mid-run affects next terminal count
        step(1'b1, 1, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        check("ar_change_done", int'(Done), 1);

        // Async reset mid-count
        step(1'b1, 9, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, 1'b0);
        check("pre_reset_count", int'(Count), 6);
        #2 Resetn = 1'b0;
        #1;
        check("async_count", int'(Count), 0);
        check("async_borrow", int'(Borrow), 0);
        check("async_done", int'(Done), 0);
        @(posedge Clock); #1;
        Resetn = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b1, 1'b1);
        check("post_reset_idle_count", int'(Count), 0);
        check("post_reset_idle_done", int'(Done), 0);

        @(negedge Clock); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
